// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between instruction fetch and
// data load/store. Byte-masked stores become a read-modify-write over two cycles.
module sram_port_arbiter #(
    parameter  int ADDR_WIDTH = 20,
    parameter  int DATA_WIDTH = 32,
    localparam int NB_BYTES   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
    output logic                  fetch_rsp_valid,
    output logic [DATA_WIDTH-1:0] fetch_rsp_data,
    input  logic                  data_req_valid,
    output logic                  data_req_ready,
    input  logic [ADDR_WIDTH-1:0] data_req_addr,
    input  logic                  data_req_we,
    input  logic [NB_BYTES-1:0]   data_req_wstrb,
    input  logic [DATA_WIDTH-1:0] data_req_wdata,
    output logic                  data_rsp_valid,
    output logic [DATA_WIDTH-1:0] data_rsp_data,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                state_q;
    logic                  rr_last_q;      // 1: data port was granted last
    logic                  fetch_rsp_q;
    logic                  data_rsp_q;
    logic                  data_rd_q;      // data response carries read data
    logic [ADDR_WIDTH-1:0] rmw_addr_q;
    logic [DATA_WIDTH-1:0] rmw_wdata_q;
    logic [NB_BYTES-1:0]   rmw_wstrb_q;

    logic                  can_grant;
    logic                  grant_f;
    logic                  grant_d;
    logic                  st_full;
    logic                  st_none;
    logic                  st_part;
    logic [DATA_WIDTH-1:0] rmw_merged;

    assign can_grant = rstn && (state_q == IDLE);
    assign grant_f   = can_grant && fetch_req_valid && (!data_req_valid || rr_last_q);
    assign grant_d   = can_grant && data_req_valid && (!fetch_req_valid || !rr_last_q);
    assign st_full   = data_req_we && (&data_req_wstrb);
    assign st_none   = data_req_we && (data_req_wstrb == '0);
    assign st_part   = data_req_we && !st_full && !st_none;

    assign fetch_req_ready = grant_f;
    assign data_req_ready  = grant_d;

    for (genvar b = 0; b < NB_BYTES; b++) begin : g_merge
        assign rmw_merged[b*8 +: 8] = rmw_wstrb_q[b] ? rmw_wdata_q[b*8 +: 8]
                                                     : sram_rdata[b*8 +: 8];
    end

    always_comb begin
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (rstn && state_q == RMW_WR) begin
            sram_we    = 1'b1;
            sram_addr  = rmw_addr_q;
            sram_wdata = rmw_merged;
        end else if (grant_f) begin
            sram_addr = fetch_req_addr;
        end else if (grant_d && !st_none) begin
            // loads and the read half of a partial store leave we low
            sram_addr  = data_req_addr;
            sram_we    = st_full;
            sram_wdata = st_full ? data_req_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            fetch_rsp_q <= 1'b0;
            data_rsp_q  <= 1'b0;
            data_rd_q   <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_wstrb_q <= '0;
        end else begin
            fetch_rsp_q <= grant_f;
            data_rsp_q  <= (grant_d && !st_part) || (state_q == RMW_WR);
            data_rd_q   <= grant_d && !data_req_we;
            if (grant_f)
                rr_last_q <= 1'b0;
            else if (grant_d)
                rr_last_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (grant_d && st_part) begin
                        state_q     <= RMW_WR;
                        rmw_addr_q  <= data_req_addr;
                        rmw_wdata_q <= data_req_wdata;
                        rmw_wstrb_q <= data_req_wstrb;
                    end
                end
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fetch_rsp_valid = fetch_rsp_q;
    assign fetch_rsp_data  = fetch_rsp_q ? sram_rdata : '0;
    assign data_rsp_valid  = data_rsp_q;
    assign data_rsp_data   = data_rd_q ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: a transaction-level model predicts
// grants, SRAM writes and responses; directed sequences cover the corner cases.
module tb_sram_port_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fetch_req_valid, fetch_req_ready, fetch_rsp_valid;
    logic [AW-1:0] fetch_req_addr;
    logic [DW-1:0] fetch_rsp_data;
    logic          data_req_valid, data_req_ready, data_req_we, data_rsp_valid;
    logic [AW-1:0] data_req_addr;
    logic [NB-1:0] data_req_wstrb;
    logic [DW-1:0] data_req_wdata, data_rsp_data;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_addr(fetch_req_addr), .fetch_rsp_valid(fetch_rsp_valid),
        .fetch_rsp_data(fetch_rsp_data),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_addr(data_req_addr), .data_req_we(data_req_we),
        .data_req_wstrb(data_req_wstrb), .data_req_wdata(data_req_wdata),
        .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    // sram1rw stand-in: registered read, write on we
    logic [DW-1:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        sram_rdata <= mem[sram_addr[7:0]];
        if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pending requests (held until accepted)
    logic          pf, pd, pdwe;
    logic [7:0]    pfa, pda;
    logic [NB-1:0] pds;
    logic [DW-1:0] pdw;

    // reference model
    logic [DW-1:0] ref_mem [256];
    logic          m_rr;       // 1: data granted last
    logic          m_busy;     // partial store write half due this cycle
    logic [7:0]    r_addr;
    logic [DW-1:0] r_wd;
    logic [NB-1:0] r_st;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] strb);
        logic [DW-1:0] r;
        for (int b = 0; b < NB; b++)
            r[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return r;
    endfunction

    task automatic set_f(input logic [7:0] a);
        pf = 1'b1; pfa = a;
    endtask

    task automatic set_d(input logic [7:0] a, input logic we, input logic [NB-1:0] s,
                         input logic [DW-1:0] w);
        pd = 1'b1; pda = a; pdwe = we; pds = s; pdw = w;
    endtask

    task automatic step();
        logic gf, gd, we_exp, ef, ed;
        logic [DW-1:0] efd, edd;
        fetch_req_valid = pf;
        fetch_req_addr  = pf ? AW'(pfa) : '0;
        data_req_valid  = pd;
        data_req_addr   = pd ? AW'(pda) : '0;
        data_req_we     = pd & pdwe;
        data_req_wstrb  = pd ? pds : '0;
        data_req_wdata  = pd ? pdw : '0;
        #1;
        gf = rstn && !m_busy && pf && (!pd || m_rr);
        gd = rstn && !m_busy && pd && (!pf || !m_rr);
        chk("f_ready", fetch_req_ready, gf);
        chk("d_ready", data_req_ready, gd);
        we_exp = rstn && (m_busy || (gd && pdwe && pds == '1));
        chk("sram_we", sram_we, we_exp);
        if (rstn && m_busy) begin
            chk("rmw_addr", sram_addr, AW'(r_addr));
            chk("rmw_wdata", sram_wdata, merge(ref_mem[r_addr], r_wd, r_st));
        end else if (gf) begin
            chk("f_sram_addr", sram_addr, AW'(pfa));
        end else if (gd && !(pdwe && pds == '0)) begin
            chk("d_sram_addr", sram_addr, AW'(pda));
            if (we_exp) chk("st_wdata", sram_wdata, pdw);
        end
        @(posedge clk);
        #1;
        ef = 0; ed = 0; efd = '0; edd = '0;
        if (!rstn) begin
            m_busy = 0; m_rr = 1;
        end else if (m_busy) begin
            ref_mem[r_addr] = merge(ref_mem[r_addr], r_wd, r_st);
            m_busy = 0; ed = 1;
        end else if (gf) begin
            ef = 1; efd = ref_mem[pfa]; m_rr = 0; pf = 0;
        end else if (gd) begin
            m_rr = 1; pd = 0; ed = 1;
            if (!pdwe) edd = ref_mem[pda];
            else if (pds == '1) ref_mem[pda] = pdw;
            else if (pds != '0) begin
                ed = 0; m_busy = 1; r_addr = pda; r_wd = pdw; r_st = pds;
            end
        end
        chk("f_rsp_valid", fetch_rsp_valid, ef);
        chk("d_rsp_valid", data_rsp_valid, ed);
        if (ef) chk("f_rsp_data", fetch_rsp_data, efd);
        if (ed) chk("d_rsp_data", data_rsp_data, edd);
    endtask

    task automatic drain();
        int k = 0;
        while ((pf || pd || m_busy) && k < 20) begin
            step();
            k++;
        end
        if (pf || pd || m_busy) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        rstn = 0; pf = 0; pd = 0; pdwe = 0; pfa = '0; pda = '0; pds = '0; pdw = '0;
        m_rr = 1; m_busy = 0; r_addr = '0; r_wd = '0; r_st = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        step(); step();
        rstn = 1;

        // preload then fetch-only, then 8 back-to-back fetches
        set_d(8'h10, 1, 4'hF, 32'hDEADBEEF); drain();
        set_f(8'h10); drain();
        for (int i = 0; i < 8; i++) begin
            set_f(8'h10 + 8'(i)); step();
        end
        drain();

        // tie after reset: F,D,F,D
        rstn = 0; step(); rstn = 1;
        for (int i = 0; i < 4; i++) begin
            if (!pf) set_f(8'(i));
            if (!pd) set_d(8'h10 + 8'(i), 0, '0, '0);
            step();
        end
        pf = 0; pd = 0;

        // full store, load back; partial store with fetch waiting
        set_d(8'h20, 1, 4'hF, 32'h12345678); drain();
        set_d(8'h20, 0, '0, '0); drain();
        set_d(8'h20, 1, 4'h5, 32'hAABBCCDD); step();
        set_f(8'h10); step(); step();
        drain();
        chk("pstore_mem", mem[8'h20], 32'h12BB56DD);
        set_d(8'h20, 1, 4'h0, 32'hFFFFFFFF); drain();
        chk("zstore_mem", mem[8'h20], 32'h12BB56DD);

        // reset during RMW_WR aborts the write; next tie goes to fetch
        set_d(8'h20, 1, 4'h3, 32'h11223344); step();
        rstn = 0; step(); rstn = 1;
        chk("abort_mem", mem[8'h20], 32'h12BB56DD);
        set_f(8'h21); set_d(8'h22, 0, '0, '0); step();
        drain();

        // randomized traffic over a small address window
        for (int c = 0; c < 800; c++) begin
            rstn = ($urandom_range(0, 59) != 0);
            if (!pf && $urandom_range(0, 1)) set_f(8'($urandom_range(0, 15)));
            if (!pd && $urandom_range(0, 1)) begin
                logic [NB-1:0] s;
                case ($urandom_range(0, 3))
                    0:       s = '0;
                    1:       s = '1;
                    default: s = NB'($urandom);
                endcase
                set_d(8'($urandom_range(0, 15)), 1'($urandom), s, $urandom);
            end
            step();
        end
        rstn = 1;
        drain();
        for (int a = 0; a < 16; a++) chk("final_mem", mem[a], ref_mem[a]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
